// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: turns raw PS/2 scan-code set 2 bytes (PS/2 clock domain)
// into key events {ext, brk, code} in the clk domain. Handles E0/F0 prefixes
// and the E1 pause tail, separates status bytes, and buffers events in a FIFO.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops repeated makes of the
// same key until that key's break has been seen.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            scan_ready,
  input  logic [7:0]                      scan_code,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [7:0]                      evt_code,
  output logic                            evt_ext,
  output logic                            evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  input  logic                            clr_ovf,
  output logic                            status_valid,
  output logic [7:0]                      status_code,
  output logic                            pause_evt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  // Device-to-host status bytes that are not key codes when seen outside a prefix.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFC, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_status = 1'b1;
      default:                                          is_status = 1'b0;
    endcase
  endfunction

  logic          sync_p0, sync_p1, hist_p2;
  logic          strobe;
  logic [7:0]    byte_p0;
  logic          vld_p0;
  state_t        state, state_nxt;
  logic [SW-1:0] skip_cnt, skip_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          push_req, push_ext, push_brk, push_en;
  logic          status_hit, pause_hit;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, wr_ok, drop;

  // ---- stage p0..p2: scan_ready synchronizer and edge history ----
  // Bring scan_ready into clk and keep one extra bit to find its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= scan_ready;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign strobe = sync_p1 & ~hist_p2;

  // ---- stage p0: byte capture; scan_code is long stable by the strobe ----
  // Latch the byte on the strobe and mark it valid for the parser next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_p0 <= 8'h00;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= strobe;
      if (strobe) byte_p0 <= scan_code;
    end
  end

  // ---- parser ----
  // Parser state, pause skip counter, prefix timeout and the status/pause pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      skip_cnt     <= '0;
      tmo_cnt      <= '0;
      status_valid <= 1'b0;
      status_code  <= 8'h00;
      pause_evt    <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (state == ST_IDLE || strobe) tmo_cnt <= '0;
      else if (!tmo_hit)              tmo_cnt <= tmo_cnt + 1'b1;
      status_valid <= status_hit;
      if (status_hit) status_code <= byte_p0;
      pause_evt <= pause_hit;
    end
  end

  // Prefix grammar: decide next state and what, if anything, the byte produces.
  always_comb begin
    state_nxt  = state;
    skip_nxt   = skip_cnt;
    push_req   = 1'b0;
    push_ext   = 1'b0;
    push_brk   = 1'b0;
    status_hit = 1'b0;
    pause_hit  = 1'b0;
    tmo_hit    = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
    if (vld_p0) begin
      case (state)
        ST_IDLE: begin
          if (byte_p0 == 8'hE0)      state_nxt = ST_EXT;
          else if (byte_p0 == 8'hF0) state_nxt = ST_BRK;
          else if (byte_p0 == 8'hE1) begin
            state_nxt = ST_SKIP;
            skip_nxt  = SW'(PAUSE_SKIP);
          end
          else if (is_status(byte_p0)) status_hit = 1'b1;
          else                         push_req   = 1'b1;
        end
        ST_EXT: begin
          if (byte_p0 == 8'hF0)      state_nxt = ST_EXT_BRK;
          else if (byte_p0 != 8'hE0) begin
            push_req  = 1'b1;
            push_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_req  = 1'b1;
          push_brk  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (byte_p0 != 8'hE0) begin
            push_req  = 1'b1;
            push_ext  = 1'b1;
            push_brk  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (skip_cnt <= SW'(1)) begin
            pause_hit = 1'b1;
            skip_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            skip_nxt = skip_cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       lm_valid, lm_ext, lm_match;
  logic [7:0] lm_code;

  assign lm_match = lm_valid && (lm_ext == push_ext) && (lm_code == byte_p0);
  assign push_en  = push_req && !(lm_match && !push_brk);

  // Remember the last make so auto-repeats of a held key are not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lm_valid <= 1'b0;
      lm_ext   <= 1'b0;
      lm_code  <= 8'h00;
    end else if (push_req) begin
      if (!push_brk) begin
        if (!lm_match) begin
          lm_valid <= 1'b1;
          lm_ext   <= push_ext;
          lm_code  <= byte_p0;
        end
      end else if (lm_match) begin
        lm_valid <= 1'b0;
      end
    end
  end
`else
  assign push_en = push_req;
`endif

  // ---- event FIFO ----
  assign evt_valid  = (count != '0);
  assign pop        = evt_valid & evt_ready;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign wr_ok      = push_en & (~full | pop);
  assign drop       = push_en & full & ~pop;
  assign fifo_count = count;
  assign {evt_ext, evt_brk, evt_code} = mem[rd_ptr];

  // Pointer/occupancy bookkeeping; a pop frees room for a same-cycle push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Event storage; the head entry drives the evt_* outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_ptr] <= {push_ext, push_brk, byte_p0};
    end
  end

  // Sticky drop flag; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule
